// File: rtl/srff_cmd_arbiter_if.sv
// Requester-side bundle for srff_cmd_arbiter: command request,
// round-robin grant and completion/status flags.
interface srff_cmd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    cmd_set;
  logic [NREQ*AW-1:0] cmd_addr;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output req, cmd_set, cmd_addr,
    input  gnt, busy, done, err
  );

  modport slave (
    input  req, cmd_set, cmd_addr,
    output gnt, busy, done, err
  );
endinterface

// File: rtl/srff_cmd_arbiter.sv
// srff_cmd_arbiter: round-robin set/reset command arbiter for an SR bank.
// Define SRFF_VERIFY_EN to add a CHECK state that reads q_in back.
module srff_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  srff_cmd_arbiter_if.slave bus,
  output logic [NFLAG-1:0]  s_out,
  output logic [NFLAG-1:0]  r_out,
  input  logic [NFLAG-1:0]  q_in
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1
`ifdef SRFF_VERIFY_EN
    , CHECK = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NFLAG-1:0]  s_q, s_d;
  logic [NFLAG-1:0]  r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic              found;
  logic [IW-1:0]     pick;
  logic              pick_op;
  logic [AW-1:0]     pick_addr;
  logic [NFLAG-1:0]  pick_oh;
  logic              addr_oor;

  // Rotate requests so the rr pointer sits at bit 0, then take the lowest.
  always_comb begin
    req2    = {bus.req, bus.req} >> rr_q;
    req_rot = req2[NREQ-1:0];
    found   = |bus.req;
    off     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum  = {1'b0, rr_q} + {1'b0, off};
    pick = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
  end

  always_comb begin
    pick_op   = 1'b0;
    pick_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_op   = bus.cmd_set[i];
        pick_addr = bus.cmd_addr[i*AW +: AW];
      end
    end
    for (int f = 0; f < NFLAG; f++) begin
      pick_oh[f] = (pick_addr == AW'(f));
    end
  end

  assign addr_oor = (int'(addr_q) >= NFLAG);

`ifdef SRFF_VERIFY_EN
  logic q_sel;
  always_comb begin
    q_sel = 1'b0;
    for (int f = 0; f < NFLAG; f++) begin
      if (addr_q == AW'(f)) q_sel = q_in[f];
    end
  end
`else
  logic unused_q;
  assign unused_q = ^{q_in, op_q};
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    gnt_d   = '0;
    s_d     = '0;
    r_d     = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          idx_d   = pick;
          op_d    = pick_op;
          addr_d  = pick_addr;
          gnt_d   = ONE << pick;
          if (pick_op) s_d = pick_oh;
          else         r_d = pick_oh;
        end
      end
      ISSUE: begin
        rr_d   = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
        done_d = 1'b1;
        if (addr_oor) err_d = 1'b1;
`ifdef SRFF_VERIFY_EN
        state_d = CHECK;
`else
        state_d = IDLE;
`endif
      end
`ifdef SRFF_VERIFY_EN
      CHECK: begin
        state_d = IDLE;
        if (!addr_oor && (q_sel != op_q)) err_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign s_out    = s_q;
  assign r_out    = r_q;
endmodule

// File: tb/tb_srff_cmd_arbiter.sv
// Testbench for srff_cmd_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model and an SR bank model.
module tb_srff_cmd_arbiter;
  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int AW    = 3;
`ifdef SRFF_VERIFY_EN
  localparam int SLOT = 3;
`else
  localparam int SLOT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NFLAG-1:0] s_out, r_out, q_in;
  logic [NFLAG-1:0] q_bank = '0;
  logic [NFLAG-1:0] qmask = '0;
  int checks = 0;
  int failures = 0;

  srff_cmd_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  srff_cmd_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .s_out (s_out),
    .r_out (r_out),
    .q_in  (q_in)
  );

  always #5 clk = ~clk;

  // Behavioural SR flip-flop bank fed by the arbiter.
  always @(posedge clk) begin
    if (rst) q_bank <= '0;
    else     q_bank <= (q_bank | s_out) & ~r_out;
  end
  assign q_in = q_bank & ~qmask;

  task automatic clear_inputs();
    bus.req      = '0;
    bus.cmd_set  = '0;
    bus.cmd_addr = '0;
  endtask

  task automatic post(input int i, input bit op, input int a);
    bus.req[i]                = 1'b1;
    bus.cmd_set[i]            = op;
    bus.cmd_addr[i*AW +: AW]  = AW'(a);
  endtask

  task automatic drop(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    qmask = '0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    post(2, 1'b1, 3);
    do_reset();
    checks++; if (bus.gnt !== 4'b0) begin failures++;
      $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    checks++; if (s_out !== 6'b0) begin failures++;
      $display("FAIL reset_s got=%b want=000000", s_out); end
    checks++; if (r_out !== 6'b0) begin failures++;
      $display("FAIL reset_r got=%b want=000000", r_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++;
      $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%b want=0", bus.err); end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    do_reset();
    post(0, 1'b1, 2);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001 || s_out !== 6'b000100) begin
      failures++;
      $display("FAIL mid_issue got=%b/%b want=0001/000100", bus.gnt, s_out);
    end
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    checks++; if (s_out !== 6'b0 || r_out !== 6'b0) begin failures++;
      $display("FAIL mid_sr got=%b/%b want=0/0", s_out, r_out); end
    checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL mid_idle got=%b/%b want=0/0", bus.gnt, bus.busy); end
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL mid_err got=%b want=0", bus.err); end
    if (bus.done !== 1'b0) quiet = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.gnt !== 4'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++;
      $display("FAIL mid_nodone got=pulse want=none"); end
  endtask

  task automatic test_set_reset();
    do_reset();
    post(1, 1'b1, 5);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010 || s_out !== 6'b100000 ||
                  r_out !== 6'b0) begin failures++;
      $display("FAIL set_issue got=%b/%b/%b want=0010/100000/000000",
               bus.gnt, s_out, r_out); end
    checks++; if (bus.busy !== 1'b1) begin failures++;
      $display("FAIL set_busy got=%b want=1", bus.busy); end
    drop(1);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || q_in[5] !== 1'b1) begin failures++;
      $display("FAIL set_done got=%b/%b want=1/1", bus.done, q_in[5]); end
    repeat (SLOT-2) @(negedge clk);
    post(1, 1'b0, 5);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010 || r_out !== 6'b100000 ||
                  s_out !== 6'b0) begin failures++;
      $display("FAIL rst_issue got=%b/%b/%b want=0010/100000/000000",
               bus.gnt, r_out, s_out); end
    drop(1);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || q_in[5] !== 1'b0) begin failures++;
      $display("FAIL rst_done got=%b/%b want=1/0", bus.done, q_in[5]); end
    repeat (2) @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL setrst_err got=%b want=0", bus.err); end
  endtask

  task automatic test_all_four();
    int gi[$];
    int gc[$];
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, 1'b1, i);
    for (int c = 1; c <= 4*SLOT + 4; c++) begin
      @(negedge clk);
      if (bus.gnt !== 4'b0) begin
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i] === 1'b1) begin
          gi.push_back(i); gc.push_back(c); drop(i);
        end
      end
    end
    checks++; if (gi.size() != 4) begin failures++;
      $display("FAIL four_count got=%0d want=4", gi.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gi[k] != k || gc[k] != 1 + k*SLOT) begin failures++;
          $display("FAIL four_slot%0d got=req%0d@%0d want=req%0d@%0d",
                   k, gi[k], gc[k], k, 1 + k*SLOT); end
      end
    end
  endtask

  task automatic test_fairness();
    int t = -1;
    int t2 = -1;
    logic [NREQ-1:0] g2 = '0;
    do_reset();
    post(3, 1'b0, 1);
    for (int c = 1; c <= 10 && t < 0; c++) begin
      @(negedge clk);
      if (bus.gnt[3] === 1'b1) t = c;
    end
    checks++; if (t < 0) begin failures++;
      $display("FAIL fair_first got=timeout want=gnt3"); return; end
    post(0, 1'b1, 0);
    for (int c = t+1; c <= t+10 && t2 < 0; c++) begin
      @(negedge clk);
      if (bus.gnt !== 4'b0) begin t2 = c; g2 = bus.gnt; end
    end
    checks++; if (g2 !== 4'b0001 || t2 != t + SLOT) begin failures++;
      $display("FAIL fair_next got=%b@%0d want=0001@%0d", g2, t2, t+SLOT); end
    drop(0);
    repeat (SLOT) @(negedge clk);
    checks++; if (bus.gnt !== 4'b1000) begin failures++;
      $display("FAIL fair_third got=%b want=1000", bus.gnt); end
    clear_inputs();
  endtask

  task automatic test_oor();
    bit held = 1'b1;
    do_reset();
    post(2, 1'b1, 7);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100 || s_out !== 6'b0 ||
                  r_out !== 6'b0) begin failures++;
      $display("FAIL oor_issue got=%b/%b/%b want=0100/0/0",
               bus.gnt, s_out, r_out); end
    drop(2);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin failures++;
      $display("FAIL oor_done got=%b/%b want=1/1", bus.done, bus.err); end
    post(0, 1'b1, 1);
    repeat (8) begin
      @(negedge clk);
      if (bus.gnt[0] === 1'b1) drop(0);
      if (bus.err !== 1'b1) held = 1'b0;
    end
    checks++; if (!held) begin failures++;
      $display("FAIL oor_sticky got=cleared want=held"); end
    do_reset();
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL oor_rst got=%b want=0", bus.err); end
  endtask

  task automatic test_verify();
    bit excl = 1'b1;
    do_reset();
    qmask = 6'b010000;
    post(1, 1'b1, 4);
    for (int c = 1; c <= SLOT + 1; c++) begin
      @(negedge clk);
      if ((s_out & r_out) !== 6'b0) excl = 1'b0;
      if (c == 1) drop(1);
      if (c == 2) begin
        checks++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
          failures++;
          $display("FAIL ver_done got=%b/%b want=1/0", bus.done, bus.err);
        end
      end
    end
`ifdef SRFF_VERIFY_EN
    checks++; if (bus.err !== 1'b1) begin failures++;
      $display("FAIL ver_mismatch got=%b want=1", bus.err); end
`else
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL ver_ignored got=%b want=0", bus.err); end
`endif
    qmask = '0;
    do_reset();
    post(2, 1'b1, 3);
    for (int c = 1; c <= SLOT + 1; c++) begin
      @(negedge clk);
      if ((s_out & r_out) !== 6'b0) excl = 1'b0;
      if (c == 1) drop(2);
    end
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL ver_match got=%b want=0", bus.err); end
    checks++; if (!excl) begin failures++;
      $display("FAIL ver_excl got=overlap want=none"); end
  endtask

  task automatic test_random();
    bit pv[NREQ];
    bit po[NREQ];
    int pa[NREQ];
    int ptr, idle_from, last_g, err_at, g, j;
    int bad = 0;
    logic [NREQ-1:0]  eg;
    logic [NFLAG-1:0] es, er;
    logic             ed, eb, ee;
    do_reset();
    ptr = 0; idle_from = 0; last_g = -10; err_at = 1 << 30;
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    for (int c = 0; c <= 400; c++) begin
      if (c > 0) begin
        @(negedge clk);
        ed = (c == last_g + 1);
        g = -1;
        if (c - 1 >= idle_from) begin
          for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (g < 0 && pv[j]) g = j;
          end
        end
        eg = '0; es = '0; er = '0;
        if (g >= 0) begin
          eg[g] = 1'b1;
          if (pa[g] < NFLAG) begin
            if (po[g]) es[pa[g]] = 1'b1;
            else       er[pa[g]] = 1'b1;
          end
          if (pa[g] >= NFLAG && err_at > c + 1) err_at = c + 1;
          last_g = c;
          idle_from = c + SLOT - 1;
          ptr = (g + 1) % NREQ;
          pv[g] = 1'b0;
        end
        eb = (c < idle_from);
        ee = (c >= err_at);
        checks++;
        if (bus.gnt !== eg || s_out !== es || r_out !== er ||
            bus.done !== ed || bus.busy !== eb || bus.err !== ee ||
            (s_out & r_out) !== 6'b0) begin
          failures++; bad++;
          if (bad <= 5)
            $display("FAIL rand_c%0d got=%b/%b/%b/%b%b%b want=%b/%b/%b/%b%b%b",
                     c, bus.gnt, s_out, r_out, bus.done, bus.busy, bus.err,
                     eg, es, er, ed, eb, ee);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          po[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) pa[i] = $urandom_range(NFLAG, 7);
          else pa[i] = $urandom_range(0, NFLAG - 1);
        end
        bus.req[i]               = pv[i];
        bus.cmd_set[i]           = po[i];
        bus.cmd_addr[i*AW +: AW] = AW'(pa[i]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_mid();
    test_set_reset();
    test_all_four();
    test_fairness();
    test_oor();
    test_verify();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
